// File: rtl/coherency_mem_responder.sv
// Memory-side target for coherency-bus line misses: queues unsupplied BusRd/BusRdX
// broadcasts, reads the backing store after a fixed latency and returns the line to the requester.
module coherency_mem_responder #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int LINE_BYTES  = 64,
    parameter int DATA_WIDTH  = LINE_BYTES * 8,
    parameter int MEM_LINES   = 1024,
    parameter int MEM_LATENCY = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_valid,
    input  logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic [1:0]                   bus_type,
    input  logic [$clog2(NUM_CORES)-1:0] granted_core_id,
    input  logic [NUM_CORES-1:0]         snoop_resp,
    output logic [NUM_CORES-1:0]         bus_resp_valid,
    output logic [DATA_WIDTH-1:0]        bus_resp_data,
    input  logic                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         wb_ready,
    output logic                         busy,
    output logic                         overflow
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CORE_W = $clog2(NUM_CORES);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int QCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [CORE_W-1:0] core;
    } miss_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Capture and queue control
    logic [NUM_CORES-1:0] w_req_onehot;
    logic [IDX_W-1:0]     w_bus_idx;
    logic [IDX_W-1:0]     w_wb_idx;
    logic                 w_is_read;
    logic                 w_capture;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused_addr;

    miss_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [QCNT_W-1:0]    r_count;
    logic                 r_overflow;

    logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    miss_t                 r_cur;
    logic [NUM_CORES-1:0]  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;

    assign w_req_onehot = NUM_CORES'(1) << granted_core_id;
    assign w_bus_idx    = bus_addr[OFF_W +: IDX_W];
    assign w_wb_idx     = wb_addr[OFF_W +: IDX_W];
    assign w_is_read    = (bus_type == 2'b01) || (bus_type == 2'b10);
    // The requester's own snoop bit never counts as a peer supplying data.
    assign w_capture    = bus_valid && w_is_read && ((snoop_resp & ~w_req_onehot) == '0);
    assign w_full       = (r_count == QCNT_W'(FIFO_DEPTH));
    assign w_push       = w_capture && !w_full;
    assign w_pop        = (r_state == ST_IDLE) && !wb_valid && (r_count != '0);

    // Address bits outside the line index are deliberately ignored (aliasing is intended).
    assign w_unused_addr = ^{bus_addr[ADDR_WIDTH-1:OFF_W+IDX_W], bus_addr[OFF_W-1:0],
                             wb_addr[ADDR_WIDTH-1:OFF_W+IDX_W], wb_addr[OFF_W-1:0]};

    // NOTE: storage arrays carry no reset; only the pointers/count define queue validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= miss_t'{idx: w_bus_idx, core: granted_core_id};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + QCNT_W'(1);
                2'b01:   r_count <= r_count - QCNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_ready) begin
            r_mem[w_wb_idx] <= wb_data;
        end
    end

    // NOTE: every register here uses <= so all transitions see pre-edge state consistently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cur        <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur   <= r_fifo[r_rd_ptr];
                        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= r_mem[r_cur.idx];
                        r_resp_valid <= NUM_CORES'(1) << r_cur.core;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= '0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_resp_valid <= '0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_resp_valid = r_resp_valid;
    assign bus_resp_data  = r_resp_data;
    assign wb_ready       = wb_valid && (r_state == ST_IDLE);
    assign busy           = (r_count != '0) || (r_state != ST_IDLE);
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_coherency_mem_responder.sv
// Directed and randomized checks of coherency_mem_responder against a transaction-level model.
module tb_coherency_mem_responder;

    localparam int NC  = 4;
    localparam int AW  = 64;
    localparam int LB  = 64;
    localparam int DW  = LB * 8;
    localparam int ML  = 1024;
    localparam int LAT = 4;
    localparam int FD  = 4;

    logic          clk;
    logic          rst;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic [1:0]    bus_type;
    logic [1:0]    granted_core_id;
    logic [NC-1:0] snoop_resp;
    logic [NC-1:0] bus_resp_valid;
    logic [DW-1:0] bus_resp_data;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;
    logic          busy;
    logic          overflow;

    coherency_mem_responder #(
        .NUM_CORES(NC), .ADDR_WIDTH(AW), .LINE_BYTES(LB), .DATA_WIDTH(DW),
        .MEM_LINES(ML), .MEM_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_type(bus_type),
        .granted_core_id(granted_core_id), .snoop_resp(snoop_resp),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .busy(busy), .overflow(overflow)
    );

    typedef struct {
        int            c;
        logic [NC-1:0] v;
        logic [DW-1:0] d;
    } resp_t;

    typedef struct {
        int            c;
        int            core;
        logic [DW-1:0] d;
    } exp_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    resp_t         resp_log [$];
    logic [DW-1:0] mdl_mem  [ML];
    int            idx_set  [8] = '{5, 9, 20, 0, 1023, 512, 77, 300};
    logic [DW-1:0] pat_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus_resp_valid !== '0) begin
            resp_log.push_back('{cyc, bus_resp_valid, bus_resp_data});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] mk_addr(input int idx);
        logic [AW-1:0] up;
        up = {$urandom, $urandom};
        return up * 64'(ML * LB) + 64'(idx * LB) + 64'($urandom_range(0, LB - 1));
    endfunction

    function automatic int line_of(input logic [AW-1:0] a);
        return int'((a / 64'(LB)) % 64'(ML));
    endfunction

    task automatic do_wb(input int idx, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = mk_addr(idx);
        wb_data  = d;
        @(negedge clk);
        check("wb_ready_idle", wb_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
        mdl_mem[idx] = d;
    endtask

    task automatic issue(input logic [1:0] typ, input int core, input logic [NC-1:0] snoop,
                         input logic [AW-1:0] addr, input string tag);
        int            t;
        bit            exp_resp;
        logic [DW-1:0] exp_d;
        exp_resp = ((typ == 2'b01) || (typ == 2'b10)) && (((int'(snoop) & ~(1 << core)) & 'hF) == 0);
        exp_d    = mdl_mem[line_of(addr)];
        resp_log.delete();
        bus_valid       = 1'b1;
        bus_type        = typ;
        bus_addr        = addr;
        granted_core_id = 2'(core);
        snoop_resp      = snoop;
        t = cyc;
        tick();
        bus_valid  = 1'b0;
        bus_type   = 2'b00;
        snoop_resp = '0;
        @(negedge clk);
        check({tag, "_busy"}, busy, exp_resp);
        while (cyc < t + LAT + 6) tick();
        @(negedge clk);
        check({tag, "_nresp"}, resp_log.size(), exp_resp);
        if (exp_resp && resp_log.size() > 0) begin
            check({tag, "_cyc"}, resp_log[0].c - t, LAT + 2);
            check({tag, "_valid"}, resp_log[0].v, 1 << core);
            check({tag, "_data"}, resp_log[0].d, exp_d);
            check({tag, "_hold"}, bus_resp_data, exp_d);
        end
        tick();
    endtask

    task automatic overflow_burst();
        int   t0;
        int   acc;
        int   pops;
        int   occ;
        int   idx;
        exp_t q [$];
        check("ovf_pre", overflow, 1'b0);
        resp_log.delete();
        t0  = cyc;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            idx  = idx_set[i];
            pops = 0;
            for (int k = 0; k < acc; k++) if (t0 + 1 + k * (LAT + 2) < t0 + i) pops++;
            occ = acc - pops;
            bus_valid       = 1'b1;
            bus_type        = 2'b10;
            bus_addr        = mk_addr(idx);
            granted_core_id = 2'(i % NC);
            snoop_resp      = NC'(1 << (i % NC));
            if (occ < FD) begin
                q.push_back('{t0 + (acc + 1) * (LAT + 2), i % NC, mdl_mem[idx]});
                acc++;
            end
            tick();
        end
        bus_valid  = 1'b0;
        snoop_resp = '0;
        while (cyc < t0 + 7 * (LAT + 2)) tick();
        @(negedge clk);
        check("ovf_nresp", resp_log.size(), q.size());
        for (int k = 0; k < q.size() && k < resp_log.size(); k++) begin
            check($sformatf("ovf_cyc%0d", k), resp_log[k].c - t0, q[k].c - t0);
            check($sformatf("ovf_valid%0d", k), resp_log[k].v, 1 << q[k].core);
            check($sformatf("ovf_data%0d", k), resp_log[k].d, q[k].d);
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_idle", busy, 1'b0);
        tick();
    endtask

    task automatic wb_during_wait();
        int            t;
        int            acc;
        logic [DW-1:0] old_d;
        logic [DW-1:0] new_d;
        old_d = mdl_mem[20];
        new_d = rand_line();
        resp_log.delete();
        t = cyc;
        bus_valid = 1'b1; bus_type = 2'b01; bus_addr = mk_addr(20);
        granted_core_id = 2'd0; snoop_resp = '0;
        tick();
        bus_addr = mk_addr(9); granted_core_id = 2'd3;
        tick();
        bus_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = mk_addr(9);
        wb_data   = new_d;
        acc = -1;
        for (int k = 0; k < 40 && acc < 0; k++) begin
            @(negedge clk);
            check($sformatf("wb_ready_t%0d", cyc - t), wb_ready, cyc >= t + LAT + 3);
            if (wb_ready) acc = cyc;
            tick();
        end
        wb_valid = 1'b0;
        mdl_mem[9] = new_d;
        check("wb_accept_cyc", acc - t, LAT + 3);
        while (cyc < t + 2 * (LAT + 2) + 6) tick();
        @(negedge clk);
        check("wbw_nresp", resp_log.size(), 2);
        if (resp_log.size() >= 2) begin
            check("wbw_cyc0", resp_log[0].c - t, LAT + 2);
            check("wbw_valid0", resp_log[0].v, 4'b0001);
            check("wbw_data0", resp_log[0].d, old_d);
            check("wbw_cyc1", resp_log[1].c - t, 2 * LAT + 5);
            check("wbw_valid1", resp_log[1].v, 4'b1000);
            check("wbw_data1", resp_log[1].d, new_d);
        end
        check("ovf_sticky", overflow, 1'b1);
        tick();
    endtask

    task automatic reset_mid();
        int t;
        resp_log.delete();
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            bus_valid = 1'b1; bus_type = 2'b01; bus_addr = mk_addr(idx_set[i + 2]);
            granted_core_id = 2'(i); snoop_resp = '0;
            tick();
        end
        bus_valid = 1'b0;
        @(negedge clk);
        check("rstm_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rstm_valid", bus_resp_valid, '0);
        check("rstm_data", bus_resp_data, '0);
        check("rstm_wb_ready", wb_ready, 1'b0);
        check("rstm_busy", busy, 1'b0);
        check("rstm_overflow", overflow, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        while (cyc < t + 20) tick();
        @(negedge clk);
        check("rstm_no_resp", resp_log.size(), 0);
        tick();
        issue(2'b01, 0, 4'b0000, mk_addr(5), "rstm_retained");
    endtask

    task automatic random_phase();
        logic [1:0]    typ;
        logic [NC-1:0] snoop;
        int            core;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) do_wb(idx_set[$urandom_range(0, 7)], rand_line());
            typ   = 2'($urandom_range(0, 3));
            core  = $urandom_range(0, NC - 1);
            snoop = ($urandom_range(0, 1) == 1) ? '0 : NC'($urandom);
            issue(typ, core, snoop, mk_addr(idx_set[$urandom_range(0, 7)]), $sformatf("rnd%0d", it));
        end
    endtask

    initial begin
        rst = 1'b0; bus_valid = 1'b0; bus_addr = '0; bus_type = 2'b00;
        granted_core_id = 2'd0; snoop_resp = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        pat_a = {8{64'hA5A5_5A5A_0123_4567}};
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus_resp_valid, '0);
        check("rst_data", bus_resp_data, '0);
        check("rst_wb_ready", wb_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        do_wb(5, pat_a);
        for (int i = 1; i < 8; i++) do_wb(idx_set[i], rand_line());

        issue(2'b01, 2, 4'b0000, 64'h140, "rd_c2");
        issue(2'b01, 1, 4'b1000, mk_addr(5), "rd_c1_peer");
        issue(2'b01, 1, 4'b0010, mk_addr(5), "rd_c1_own");
        issue(2'b10, 3, 4'b1000, mk_addr(77), "rdx_c3_own");
        issue(2'b11, 0, 4'b0000, mk_addr(9), "upgr");
        issue(2'b00, 3, 4'b0000, mk_addr(9), "rsvd");

        overflow_burst();
        wb_during_wait();
        reset_mid();
        random_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
